fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2..8.
REQ-002 clock  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 address_imem  output  12  imem read address; imem returns the word on q_imem one cycle later.
REQ-005 q_imem  input  32  imem read data for the address presented in the previous cycle.
REQ-006 redirect  input  1  consumer taken branch/jump; flush and refetch.
REQ-007 redirect_pc  input  12  new fetch address, sampled when redirect=1.
REQ-008 deq_ready  input  1  consumer accepts the head entry.
REQ-009 deq_valid  output  1  head entry valid.
REQ-010 deq_instr  output  32  head instruction word.
REQ-011 deq_pc  output  12  address the head instruction was fetched from.
REQ-012 count  output  4  number of valid queue entries, 0..DEPTH.
REQ-013 fq_bubbles  output  16  bubble counter (see Configuration).

Function
REQ-014 State: fetch_pc (12b), pend flag (1b), circular buffer of DEPTH {instr, pc} entries, read/write pointers, count.
REQ-015 Issue condition: issue = (count + pend) < DEPTH, using registered values only.
REQ-016 address_imem SHALL equal redirect_pc when redirect=1, else fetch_pc.
REQ-017 On issue without redirect: fetch_pc <= fetch_pc+1 mod 4096 (4095 wraps to 0); pend <= 1; otherwise pend <= 0.
REQ-018 When pend=1 and redirect=0, {q_imem, pc of issuing cycle} SHALL be written at the write pointer; pointer advances mod DEPTH.
REQ-019 deq_valid = (count != 0) and redirect=0; deq_instr/deq_pc driven from the read pointer entry.
REQ-020 Pop occurs when deq_valid and deq_ready; read pointer advances mod DEPTH.
REQ-021 Push and pop in the same cycle: count unchanged. Pop with count=0: no effect.
REQ-022 Overflow is impossible by REQ-015; a write SHALL never occur with count=DEPTH.
REQ-023 Redirect cycle: count <= 0, pointers <= 0, the q_imem word arriving this cycle is discarded, any deq_ready is ignored, fetch_pc <= redirect_pc+1 mod 4096, pend <= 1.
REQ-024 Redirect latency: redirect at cycle t gives deq_valid=1 with deq_pc=redirect_pc at cycle t+2.
REQ-025 Steady state with deq_ready held high SHALL sustain one dequeue per cycle after the first two cycles.
REQ-026 Back-to-back redirects: each one restarts REQ-023/024 from its own cycle; only the last target is delivered.

Reset
REQ-027 With reset=0 at a rising edge: fetch_pc=0, pend=0, pointers=0, count=0, fq_bubbles=0.
REQ-028 During reset, outputs SHALL be deq_valid=0, count=0, and address_imem=0 unless redirect=1; redirect is ignored during reset.
REQ-029 Reset asserted mid-operation SHALL discard all entries and the in-flight fetch; the first cycle after release issues address 0, and deq_valid rises two cycles later.

Configuration
REQ-030 Macro FETCH_QUEUE_STATS_EN defined:
- fq_bubbles counts cycles with deq_ready=1, deq_valid=0, reset=1.
- Counter saturates at 16'hFFFF.
- Cleared only by reset, not by redirect.
REQ-031 FETCH_QUEUE_STATS_EN undefined: fq_bubbles SHALL be constant 0 and no counter logic is synthesized.

Verification
REQ-032 Reset release, imem[i]=32'h1000_0000+i, deq_ready=1 -> deq_valid at cycle 2, then deq_pc 0,1,2,... one per cycle with matching instr.
REQ-033 deq_ready=0 for 10 cycles -> count reaches 4 and holds, address_imem stops at 4, no writes; deq_ready=1 then pops pc 0..3 in order with no loss or duplication.
REQ-034 redirect=1, redirect_pc=12'h0A5 while count=3 and pend=1 -> count=0 next cycle, stale word dropped, deq_pc=0x0A5 at t+2, then 0x0A6.
REQ-035 redirect_pc=12'hFFE, deq_ready=1 -> deq_pc sequence FFE, FFF, 000, 001.
REQ-036 Reset pulled low for one cycle while count=2 -> count=0, deq_valid=0, next delivered deq_pc=0.
REQ-037 FETCH_QUEUE_STATS_EN defined: 3 consecutive redirects with deq_ready=1 -> fq_bubbles increments 4; undefined -> fq_bubbles stays 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Decoupling instruction fetch queue between a one-cycle-latency imem and the decode stage.
// Optional stall statistics are enabled with the FETCH_QUEUE_STATS_EN macro.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic [11:0] address_imem,
    input  logic [31:0] q_imem,
    input  logic        redirect,
    input  logic [11:0] redirect_pc,
    input  logic        deq_ready,
    output logic        deq_valid,
    output logic [31:0] deq_instr,
    output logic [11:0] deq_pc,
    output logic [3:0]  count,
    output logic [15:0] fq_bubbles
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   instr_mem [DEPTH];
    logic [11:0]   pc_mem    [DEPTH];
    logic [11:0]   fetch_pc;
    logic [11:0]   pend_pc;
    logic          pend;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [3:0]    count_r;
    logic          issue;
    logic          push;
    logic          pop;

    // A fetch is only issued when the entry it will fill is guaranteed free.
    assign issue = (count_r + {3'b000, pend}) < 4'(DEPTH);
    assign push  = pend && !redirect;
    assign pop   = deq_valid && deq_ready;

    assign deq_valid    = reset && (count_r != 4'd0) && !redirect;
    assign deq_instr    = instr_mem[rd_ptr];
    assign deq_pc       = pc_mem[rd_ptr];
    assign count        = reset ? count_r : 4'd0;
    assign address_imem = redirect ? redirect_pc : (reset ? fetch_pc : 12'h000);

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc <= 12'h000;
            pend_pc  <= 12'h000;
            pend     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_r  <= 4'd0;
        end else if (redirect) begin
            // The target is fetched this cycle, so the next fetch is target+1.
            fetch_pc <= redirect_pc + 12'd1;
            pend_pc  <= redirect_pc;
            pend     <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_r  <= 4'd0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + 12'd1;
                pend_pc  <= fetch_pc;
                pend     <= 1'b1;
            end else begin
                pend     <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_r <= count_r + 4'd1;
                2'b01:   count_r <= count_r - 4'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset && push) begin
            instr_mem[wr_ptr] <= q_imem;
            pc_mem[wr_ptr]    <= pend_pc;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [15:0] bubble_cnt;

    // Counts cycles where the consumer wanted an instruction but none was offered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            bubble_cnt <= 16'h0000;
        end else if (deq_ready && !deq_valid && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'h0001;
        end
    end

    assign fq_bubbles = bubble_cnt;
`else
    assign fq_bubbles = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: expected fetch PCs are queued on each restart
// (reset release or redirect) and consumed as the DUT dequeues.
module tb_fetch_queue;

    logic        clock;
    logic        reset;
    logic [11:0] address_imem;
    logic [31:0] q_imem;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_instr;
    logic [11:0] deq_pc;
    logic [3:0]  count;
    logic [15:0] fq_bubbles;

    int checks   = 0;
    int failures = 0;
    int pop_count = 0;
    logic [11:0] exp_q [$];
    logic [15:0] bubbles_before;

`ifdef FETCH_QUEUE_STATS_EN
    localparam int BUBBLE_DELTA = 4;
`else
    localparam int BUBBLE_DELTA = 0;
`endif

    int fill_count [10] = '{0, 0, 1, 2, 3, 4, 4, 4, 4, 4};

    fetch_queue #(.DEPTH(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_imem (address_imem),
        .q_imem       (q_imem),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .deq_ready    (deq_ready),
        .deq_valid    (deq_valid),
        .deq_instr    (deq_instr),
        .deq_pc       (deq_pc),
        .count        (count),
        .fq_bubbles   (fq_bubbles)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // imem model: the word at address a is 0x1000_0000 + a, one cycle after the address.
    always @(posedge clock) begin
        q_imem <= 32'h1000_0000 + {20'h00000, address_imem};
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic redir, input logic [11:0] rpc, input logic rdy);
        @(posedge clock);
        #1;
        reset       = rst;
        redirect    = redir;
        redirect_pc = rpc;
        deq_ready   = rdy;
    endtask

    task automatic sample();
        @(negedge clock);
        #1;
    endtask

    task automatic restart(input logic [11:0] target);
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(target + 12'(i));
        end
        pop_count = 0;
    endtask

    // Every accepted dequeue must match the next expected PC and its imem word.
    always @(negedge clock) begin
        logic [11:0] exp_pc;
        if (deq_valid === 1'b1 && deq_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_pc = exp_q.pop_front();
                checkOutput("deq_pc", 32'(deq_pc), 32'(exp_pc));
                checkOutput("deq_instr", deq_instr, 32'h1000_0000 + 32'(exp_pc));
                pop_count++;
            end
        end
    end

    initial begin
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 12'h000;
        deq_ready   = 1'b0;

        // Reset behaviour, including redirect passthrough on the address.
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
        sample();
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_valid", 32'(deq_valid), 32'd0);
        checkOutput("rst_addr", 32'(address_imem), 32'd0);
        applyStimulus(1'b0, 1'b1, 12'h123, 1'b1);
        sample();
        checkOutput("rst_addr_redir", 32'(address_imem), 32'h123);
        checkOutput("rst_valid_redir", 32'(deq_valid), 32'd0);
        checkOutput("rst_bubbles", 32'(fq_bubbles), 32'd0);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b1);
        sample();
        checkOutput("rst_addr2", 32'(address_imem), 32'd0);

        // Release with the consumer always ready: valid at cycle 2, then one per cycle.
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 1'b0, 12'h000, 1'b1);
            if (c == 0) restart(12'h000);
            sample();
            if (c == 0) checkOutput("rel_addr0", 32'(address_imem), 32'd0);
            checkOutput("rel_valid", 32'(deq_valid), (c >= 2) ? 32'd1 : 32'd0);
        end
        checkOutput("rel_pops", 32'(pop_count), 32'd8);

        // Stalled consumer: queue fills to 4 and fetching stops at address 4.
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 1'b0, 12'h000, 1'b0);
            if (c == 0) restart(12'h000);
            sample();
            checkOutput("stall_count", 32'(count), 32'(fill_count[c]));
            if (c >= 4) checkOutput("stall_addr", 32'(address_imem), 32'd4);
        end
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, 1'b0, 12'h000, 1'b1);
            sample();
        end
        checkOutput("stall_pops", 32'(pop_count), 32'd8);

        // Redirect while count=3 with a fetch in flight.
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 1'b0, 12'h000, 1'b0);
            if (c == 0) restart(12'h000);
            sample();
        end
        checkOutput("redir_pre_count", 32'(count), 32'd2);
        applyStimulus(1'b1, 1'b1, 12'h0A5, 1'b1);
        restart(12'h0A5);
        sample();
        checkOutput("redir_count3", 32'(count), 32'd3);
        checkOutput("redir_addr", 32'(address_imem), 32'h0A5);
        checkOutput("redir_valid_t", 32'(deq_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 12'h000, 1'b1);
        sample();
        checkOutput("redir_count_t1", 32'(count), 32'd0);
        checkOutput("redir_valid_t1", 32'(deq_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 12'h000, 1'b1);
        sample();
        checkOutput("redir_valid_t2", 32'(deq_valid), 32'd1);
        checkOutput("redir_pc_t2", 32'(deq_pc), 32'h0A5);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 1'b0, 12'h000, 1'b1);
            sample();
        end
        checkOutput("redir_pops", 32'(pop_count), 32'd3);

        // Address wrap from the top of the 12-bit space.
        applyStimulus(1'b1, 1'b1, 12'hFFE, 1'b1);
        restart(12'hFFE);
        sample();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 1'b0, 12'h000, 1'b1);
            sample();
        end
        checkOutput("wrap_pops", 32'(pop_count), 32'd5);

        // One-cycle reset while two entries are held.
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 1'b0, 12'h000, 1'b0);
            if (c == 0) restart(12'h000);
            sample();
        end
        checkOutput("midrst_pre_count", 32'(count), 32'd2);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0);
        sample();
        checkOutput("midrst_count", 32'(count), 32'd0);
        checkOutput("midrst_valid", 32'(deq_valid), 32'd0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 1'b0, 12'h000, 1'b1);
            if (c == 0) restart(12'h000);
            sample();
            checkOutput("midrst_rel_valid", 32'(deq_valid), (c >= 2) ? 32'd1 : 32'd0);
            if (c == 2) checkOutput("midrst_first_pc", 32'(deq_pc), 32'd0);
        end
        checkOutput("midrst_pops", 32'(pop_count), 32'd3);

        // Three back-to-back redirects with the consumer ready.
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 1'b0, 12'h000, 1'b1);
            sample();
        end
        checkOutput("b2b_pre_valid", 32'(deq_valid), 32'd1);
        bubbles_before = fq_bubbles;
        applyStimulus(1'b1, 1'b1, 12'h200, 1'b1);
        restart(12'h200);
        sample();
        applyStimulus(1'b1, 1'b1, 12'h300, 1'b1);
        restart(12'h300);
        sample();
        applyStimulus(1'b1, 1'b1, 12'h400, 1'b1);
        restart(12'h400);
        sample();
        checkOutput("b2b_addr", 32'(address_imem), 32'h400);
        applyStimulus(1'b1, 1'b0, 12'h000, 1'b1);
        sample();
        checkOutput("b2b_valid_t3", 32'(deq_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 12'h000, 1'b1);
        sample();
        checkOutput("b2b_bubbles", 32'(fq_bubbles), 32'(bubbles_before) + 32'(BUBBLE_DELTA));
        checkOutput("b2b_valid_t4", 32'(deq_valid), 32'd1);
        checkOutput("b2b_pc_t4", 32'(deq_pc), 32'h400);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 1'b0, 12'h000, 1'b1);
            sample();
        end
        checkOutput("b2b_pops", 32'(pop_count), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
